// File: rtl/fpu_arbiter.sv
// Two-requester round-robin front end for a shared FPU: registers one operation, screens it through
// the exception checker, launches it, bounds the wait, and holds the response until it is consumed.
module fpu_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       REQ0_VALID,
  input  logic [1:0] REQ0_OP,
  input  logic [7:0] REQ0_A,
  input  logic [7:0] REQ0_B,
  output logic       REQ0_READY,
  input  logic       REQ1_VALID,
  input  logic [1:0] REQ1_OP,
  input  logic [7:0] REQ1_A,
  input  logic [7:0] REQ1_B,
  output logic       REQ1_READY,
  output logic [1:0] FPU_OP,
  output logic [7:0] FPU_A,
  output logic [7:0] FPU_B,
  output logic       FPU_START,
  input  logic       FPU_EXCEPTION,
  input  logic       FPU_DONE,
  input  logic [7:0] FPU_RESULT,
  output logic       RSP_VALID,
  output logic       RSP_ID,
  output logic [7:0] RSP_RESULT,
  output logic       RSP_EXCEPTION,
  output logic       RSP_TIMEOUT,
  input  logic       RSP_READY
);

  localparam logic [7:0] TimeoutVal = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StCheck, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic        last_gnt_q, last_gnt_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cnt_inc;
  logic [1:0]  op_q, op_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic        rsp_id_q, rsp_id_d;
  logic [7:0]  rsp_result_q, rsp_result_d;
  logic        rsp_exc_q, rsp_exc_d;
  logic        rsp_tmo_q, rsp_tmo_d;
  logic        gnt1;
  logic        any_valid;
  logic        idle_en;

  // Grant REQ1 when it is alone, or when both contend and REQ0 was served last.
  always_comb begin
    any_valid  = REQ0_VALID | REQ1_VALID;
    gnt1       = REQ1_VALID & (~REQ0_VALID | ~last_gnt_q);
    idle_en    = (state_q == StIdle) & RST_N;
    REQ0_READY = idle_en & any_valid & ~gnt1;
    REQ1_READY = idle_en & gnt1;
    FPU_START  = (state_q == StCheck) & ~FPU_EXCEPTION;
    RSP_VALID  = (state_q == StResp);
  end

  always_comb begin
    state_d      = state_q;
    last_gnt_d   = last_gnt_q;
    cnt_d        = cnt_q;
    cnt_inc      = cnt_q + 8'd1;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_exc_d    = rsp_exc_q;
    rsp_tmo_d    = rsp_tmo_q;

    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          rsp_id_d = gnt1;
          op_d     = gnt1 ? REQ1_OP : REQ0_OP;
          a_d      = gnt1 ? REQ1_A  : REQ0_A;
          b_d      = gnt1 ? REQ1_B  : REQ0_B;
          state_d  = StCheck;
        end
      end
      StCheck: begin
        if (FPU_EXCEPTION) begin
          rsp_result_d = 8'h00;
          rsp_exc_d    = 1'b1;
          rsp_tmo_d    = 1'b0;
          state_d      = StResp;
        end else begin
          cnt_d   = 8'd0;
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_inc;
        // Completion takes priority over a timeout landing in the same cycle.
        if (FPU_DONE) begin
          rsp_result_d = FPU_RESULT;
          rsp_exc_d    = 1'b0;
          rsp_tmo_d    = 1'b0;
          state_d      = StResp;
        end else if (cnt_inc == TimeoutVal) begin
          rsp_result_d = 8'h00;
          rsp_exc_d    = 1'b0;
          rsp_tmo_d    = 1'b1;
          state_d      = StResp;
        end
      end
      StResp: begin
        if (RSP_READY) begin
          last_gnt_d = rsp_id_q;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= StIdle;
      last_gnt_q   <= 1'b1;
      cnt_q        <= 8'd0;
      op_q         <= 2'd0;
      a_q          <= 8'd0;
      b_q          <= 8'd0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= 8'd0;
      rsp_exc_q    <= 1'b0;
      rsp_tmo_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_gnt_q   <= last_gnt_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_exc_q    <= rsp_exc_d;
      rsp_tmo_q    <= rsp_tmo_d;
    end
  end

  assign FPU_OP        = op_q;
  assign FPU_A         = a_q;
  assign FPU_B         = b_q;
  assign RSP_ID        = rsp_id_q;
  assign RSP_RESULT    = rsp_result_q;
  assign RSP_EXCEPTION = rsp_exc_q;
  assign RSP_TIMEOUT   = rsp_tmo_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Bench for fpu_arbiter: directed transaction table, reset corner cases, and random traffic
// checked against a transaction-age reference model.
module tb_fpu_arbiter;

  localparam int TO = 4;

  logic       CLK;
  logic       RST_N;
  logic       REQ0_VALID, REQ1_VALID;
  logic [1:0] REQ0_OP, REQ1_OP;
  logic [7:0] REQ0_A, REQ0_B, REQ1_A, REQ1_B;
  logic       REQ0_READY, REQ1_READY;
  logic [1:0] FPU_OP;
  logic [7:0] FPU_A, FPU_B;
  logic       FPU_START, FPU_EXCEPTION, FPU_DONE;
  logic [7:0] FPU_RESULT;
  logic       RSP_VALID, RSP_ID, RSP_EXCEPTION, RSP_TIMEOUT, RSP_READY;
  logic [7:0] RSP_RESULT;

  int n_cmp = 0;
  int n_err = 0;

  fpu_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ0_VALID(REQ0_VALID), .REQ0_OP(REQ0_OP), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B),
    .REQ0_READY(REQ0_READY),
    .REQ1_VALID(REQ1_VALID), .REQ1_OP(REQ1_OP), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B),
    .REQ1_READY(REQ1_READY),
    .FPU_OP(FPU_OP), .FPU_A(FPU_A), .FPU_B(FPU_B), .FPU_START(FPU_START),
    .FPU_EXCEPTION(FPU_EXCEPTION), .FPU_DONE(FPU_DONE), .FPU_RESULT(FPU_RESULT),
    .RSP_VALID(RSP_VALID), .RSP_ID(RSP_ID), .RSP_RESULT(RSP_RESULT),
    .RSP_EXCEPTION(RSP_EXCEPTION), .RSP_TIMEOUT(RSP_TIMEOUT), .RSP_READY(RSP_READY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rdy0"}, 32'(REQ0_READY), 32'd0);
    chk({tag, "_rdy1"}, 32'(REQ1_READY), 32'd0);
    chk({tag, "_start"}, 32'(FPU_START), 32'd0);
    chk({tag, "_op"}, 32'(FPU_OP), 32'd0);
    chk({tag, "_a"}, 32'(FPU_A), 32'd0);
    chk({tag, "_b"}, 32'(FPU_B), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(RSP_VALID), 32'd0);
    chk({tag, "_rsp_id"}, 32'(RSP_ID), 32'd0);
    chk({tag, "_rsp_res"}, 32'(RSP_RESULT), 32'd0);
    chk({tag, "_rsp_exc"}, 32'(RSP_EXCEPTION), 32'd0);
    chk({tag, "_rsp_tmo"}, 32'(RSP_TIMEOUT), 32'd0);
  endtask

  // One table row is a full transaction; REQ1 carries the bitwise complement of the row operands.
  typedef struct {
    bit         v0;
    bit         v1;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    bit         exc;
    int         done_at;  // WAIT cycle (1-based) on which DONE rises; 0 = never
    logic [7:0] res;
    int         hold;     // cycles RSP_READY stays low once the response is up
    bit         e_id;
    logic [7:0] e_res;
    bit         e_exc;
    bit         e_tmo;
    int         e_lat;    // cycles from accept to first RSP_VALID
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v, input int idx);
    logic [1:0] e_op;
    logic [7:0] e_a;
    logic [7:0] e_b;
    e_op = v.e_id ? ~v.op : v.op;
    e_a  = v.e_id ? ~v.a : v.a;
    e_b  = v.e_id ? ~v.b : v.b;
    #1;
    REQ0_VALID = v.v0; REQ0_OP = v.op;  REQ0_A = v.a;  REQ0_B = v.b;
    REQ1_VALID = v.v1; REQ1_OP = ~v.op; REQ1_A = ~v.a; REQ1_B = ~v.b;
    FPU_EXCEPTION = 1'b0; FPU_DONE = 1'b0; FPU_RESULT = v.res; RSP_READY = 1'b0;
    @(negedge CLK);
    chk($sformatf("v%0d_rdy0", idx), 32'(REQ0_READY), 32'(v.e_id == 1'b0));
    chk($sformatf("v%0d_rdy1", idx), 32'(REQ1_READY), 32'(v.e_id == 1'b1));
    chk($sformatf("v%0d_idle_rsp", idx), 32'(RSP_VALID), 32'd0);
    @(posedge CLK);
    for (int k = 1; k <= 40; k++) begin
      #1;
      FPU_EXCEPTION = (k == 1) && v.exc;
      FPU_DONE      = (v.done_at > 0) && (k == 1 + v.done_at);
      RSP_READY     = (k >= v.e_lat + v.hold);
      @(negedge CLK);
      chk($sformatf("v%0d_k%0d_start", idx, k), 32'(FPU_START), 32'((k == 1) && !v.exc));
      chk($sformatf("v%0d_k%0d_rdy", idx, k), 32'({REQ1_READY, REQ0_READY}), 32'd0);
      chk($sformatf("v%0d_k%0d_rsp_valid", idx, k), 32'(RSP_VALID), 32'(k >= v.e_lat));
      if (k >= v.e_lat) begin
        chk($sformatf("v%0d_k%0d_id", idx, k), 32'(RSP_ID), 32'(v.e_id));
        chk($sformatf("v%0d_k%0d_res", idx, k), 32'(RSP_RESULT), 32'(v.e_res));
        chk($sformatf("v%0d_k%0d_exc", idx, k), 32'(RSP_EXCEPTION), 32'(v.e_exc));
        chk($sformatf("v%0d_k%0d_tmo", idx, k), 32'(RSP_TIMEOUT), 32'(v.e_tmo));
        chk($sformatf("v%0d_k%0d_fpu", idx, k), 32'({FPU_OP, FPU_A, FPU_B}), 32'({e_op, e_a, e_b}));
      end
      @(posedge CLK);
      if (k >= v.e_lat + v.hold) break;
    end
  endtask

  // Reference model: tracks how many cycles the in-flight operation has been accepted.
  bit         m_busy, m_rsp, m_last, m_id, m_exc, m_tmo;
  int         m_age;
  logic [7:0] m_res, m_a, m_b;
  logic [1:0] m_op;

  task automatic model_check_and_step(input int c);
    bit idle, e_r0, e_r1, e_st;
    idle = !m_busy && !m_rsp && RST_N;
    e_r0 = idle && REQ0_VALID && (!REQ1_VALID || m_last);
    e_r1 = idle && REQ1_VALID && (!REQ0_VALID || !m_last);
    e_st = m_busy && (m_age == 1) && !FPU_EXCEPTION;
    chk($sformatf("r%0d_rdy0", c), 32'(REQ0_READY), 32'(e_r0));
    chk($sformatf("r%0d_rdy1", c), 32'(REQ1_READY), 32'(e_r1));
    chk($sformatf("r%0d_start", c), 32'(FPU_START), 32'(e_st));
    chk($sformatf("r%0d_rsp_valid", c), 32'(RSP_VALID), 32'(m_rsp));
    if (m_rsp) begin
      chk($sformatf("r%0d_rsp", c), 32'({RSP_ID, RSP_RESULT, RSP_EXCEPTION, RSP_TIMEOUT}),
          32'({m_id, m_res, m_exc, m_tmo}));
    end
    if (m_busy || m_rsp) begin
      chk($sformatf("r%0d_fpu", c), 32'({FPU_OP, FPU_A, FPU_B}), 32'({m_op, m_a, m_b}));
    end
    if (!RST_N) begin
      m_busy = 0; m_rsp = 0; m_last = 1;
    end else if (idle) begin
      if (REQ0_VALID || REQ1_VALID) begin
        m_id = e_r1;
        m_op = m_id ? REQ1_OP : REQ0_OP;
        m_a  = m_id ? REQ1_A : REQ0_A;
        m_b  = m_id ? REQ1_B : REQ0_B;
        m_busy = 1; m_age = 1;
      end
    end else if (m_busy) begin
      if (m_age == 1) begin
        if (FPU_EXCEPTION) begin
          m_busy = 0; m_rsp = 1; m_res = 8'h00; m_exc = 1; m_tmo = 0;
        end else begin
          m_age = 2;
        end
      end else if (FPU_DONE) begin
        m_busy = 0; m_rsp = 1; m_res = FPU_RESULT; m_exc = 0; m_tmo = 0;
      end else if (m_age - 1 == TO) begin
        m_busy = 0; m_rsp = 1; m_res = 8'h00; m_exc = 0; m_tmo = 1;
      end else begin
        m_age++;
      end
    end else if (RSP_READY) begin
      m_rsp = 0; m_last = m_id;
    end
  endtask

  initial begin
    vecs[0] = '{1, 1, 2'b00, 8'h3C, 8'h12, 0, 3, 8'h45, 0, 0, 8'h45, 0, 0, 5};
    vecs[1] = '{1, 1, 2'b01, 8'h11, 8'h22, 0, 1, 8'h7E, 0, 1, 8'h7E, 0, 0, 3};
    vecs[2] = '{1, 1, 2'b10, 8'h80, 8'h00, 1, 0, 8'hAA, 0, 0, 8'h00, 1, 0, 2};
    vecs[3] = '{1, 0, 2'b00, 8'h3C, 8'h12, 0, 3, 8'h45, 0, 0, 8'h45, 0, 0, 5};
    vecs[4] = '{1, 1, 2'b11, 8'h01, 8'h02, 0, 0, 8'h33, 0, 1, 8'h00, 0, 1, 6};
    vecs[5] = '{0, 1, 2'b01, 8'hF0, 8'h0F, 0, 4, 8'h5A, 5, 1, 8'h5A, 0, 0, 6};
    vecs[6] = '{1, 1, 2'b10, 8'h55, 8'h66, 0, 2, 8'hC3, 1, 0, 8'hC3, 0, 0, 4};
    vecs[7] = '{1, 0, 2'b11, 8'h7F, 8'h01, 1, 0, 8'h00, 2, 0, 8'h00, 1, 0, 2};

    RST_N = 1'b0;
    REQ0_VALID = 1'b1; REQ0_OP = 2'b01; REQ0_A = 8'h11; REQ0_B = 8'h22;
    REQ1_VALID = 1'b1; REQ1_OP = 2'b10; REQ1_A = 8'h33; REQ1_B = 8'h44;
    FPU_EXCEPTION = 1'b0; FPU_DONE = 1'b0; FPU_RESULT = 8'h00; RSP_READY = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    check_all_zero("reset");
    @(posedge CLK);
    #1 RST_N = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Reset while waiting on the FPU: nothing may surface afterwards.
    #1;
    REQ0_VALID = 1'b1; REQ1_VALID = 1'b0; FPU_EXCEPTION = 1'b0; FPU_DONE = 1'b0;
    RSP_READY = 1'b1;
    @(posedge CLK);
    #1 REQ0_VALID = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1 RST_N = 1'b0;
    @(negedge CLK);
    chk("wait_no_start", 32'(FPU_START), 32'd0);
    chk("wait_no_rsp", 32'(RSP_VALID), 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    check_all_zero("mid_reset");
    @(posedge CLK);
    #1 RST_N = 1'b1; FPU_DONE = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk($sformatf("post_rst%0d_rsp", k), 32'(RSP_VALID), 32'd0);
      chk($sformatf("post_rst%0d_start", k), 32'(FPU_START), 32'd0);
      @(posedge CLK);
    end

    for (int c = 0; c < 3000; c++) begin
      #1;
      RST_N         = !((c == 0) || ($urandom_range(0, 99) == 0));
      REQ0_VALID    = $urandom_range(0, 1) == 1;
      REQ1_VALID    = $urandom_range(0, 1) == 1;
      REQ0_OP       = 2'($urandom);
      REQ1_OP       = 2'($urandom);
      REQ0_A        = 8'($urandom);
      REQ0_B        = 8'($urandom);
      REQ1_A        = 8'($urandom);
      REQ1_B        = 8'($urandom);
      FPU_EXCEPTION = $urandom_range(0, 3) == 0;
      FPU_DONE      = $urandom_range(0, 3) == 0;
      FPU_RESULT    = 8'($urandom);
      RSP_READY     = $urandom_range(0, 1) == 1;
      @(negedge CLK);
      model_check_and_step(c);
      @(posedge CLK);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
